input_debounce: RTL

INPUT_DEBOUNCE -- requirements
Module: input_debounce

---
 rtl/input_debounce.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/input_debounce.sv
// input_debounce: SYNC_STAGES-flop synchronizer feeding a 4-state stability FSM; Out_clean follows a clean step after
// SYNC_STAGES+STABLE_CYCLES edges, no backpressure. Rise/Fall pulses exist only when INPUT_DEBOUNCE_EDGE_EN is defined.
module input_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic In_raw,
  output logic Out_clean,
  output logic Rise,
  output logic Fall
);

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    WAIT_HIGH   = 2'd1,
    HIGH_STABLE = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit               LP_ONE  = (STABLE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_out;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], In_raw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef INPUT_DEBOUNCE_EDGE_EN
  logic r_rise;
  logic r_fall;
`endif

  // A mismatching s always either advances the count or commits; a matching s drops back to the stable state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= LOW_STABLE;
      r_cnt   <= '0;
      r_out   <= 1'b0;
`ifdef INPUT_DEBOUNCE_EDGE_EN
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
`endif
    end else begin
`ifdef INPUT_DEBOUNCE_EDGE_EN
      r_rise <= 1'b0;
      r_fall <= 1'b0;
`endif
      case (r_state)
        LOW_STABLE: begin
          if (w_s) begin
            if (LP_ONE) begin
              r_state <= HIGH_STABLE;
              r_cnt   <= '0;
              r_out   <= 1'b1;
`ifdef INPUT_DEBOUNCE_EDGE_EN
              r_rise  <= 1'b1;
`endif
            end else begin
              r_state <= WAIT_HIGH;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        WAIT_HIGH: begin
          if (!w_s) begin
            r_state <= LOW_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == LP_LAST) begin
            r_state <= HIGH_STABLE;
            r_cnt   <= '0;
            r_out   <= 1'b1;
`ifdef INPUT_DEBOUNCE_EDGE_EN
            r_rise  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HIGH_STABLE: begin
          if (!w_s) begin
            if (LP_ONE) begin
              r_state <= LOW_STABLE;
              r_cnt   <= '0;
              r_out   <= 1'b0;
`ifdef INPUT_DEBOUNCE_EDGE_EN
              r_fall  <= 1'b1;
`endif
            end else begin
              r_state <= WAIT_LOW;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        WAIT_LOW: begin
          if (w_s) begin
            r_state <= HIGH_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == LP_LAST) begin
            r_state <= LOW_STABLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
`ifdef INPUT_DEBOUNCE_EDGE_EN
            r_fall  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= LOW_STABLE;
          r_cnt   <= '0;
          r_out   <= 1'b0;
        end
      endcase
    end
  end

  assign Out_clean = r_out;

`ifdef INPUT_DEBOUNCE_EDGE_EN
  assign Rise = r_rise;
  assign Fall = r_fall;
`else
  assign Rise = 1'b0;
  assign Fall = 1'b0;
`endif

endmodule
